// File: rtl/mux2_stream_arbiter_if.sv
// mux2_stream_arbiter_if: two valid/ready/last sources, the mux select and the buffered output stream.
interface mux2_stream_arbiter_if #(parameter int DW = 8);
  logic          i0_valid;
  logic [DW-1:0] i0_data;
  logic          i0_last;
  logic          i0_ready;
  logic          i1_valid;
  logic [DW-1:0] i1_data;
  logic          i1_last;
  logic          i1_ready;
  logic          sel;
  logic          y_valid;
  logic [DW-1:0] y_data;
  logic          y_last;
  logic          y_ready;
  modport master (
    output i0_valid, i0_data, i0_last, i1_valid, i1_data, i1_last, y_ready,
    input  i0_ready, i1_ready, sel, y_valid, y_data, y_last
  );
  modport slave (
    input  i0_valid, i0_data, i0_last, i1_valid, i1_data, i1_last, y_ready,
    output i0_ready, i1_ready, sel, y_valid, y_data, y_last
  );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: packet-aware round-robin arbiter with registered mux select and one-entry output buffer.
module mux2_stream_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mux2_stream_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t        state, nxt;
  logic          rr;
  logic [7:0]    cnt;
  logic          gch, can_load, xfer, xlast, rel, own_valid, other_valid;
  logic [DW-1:0] xdata;
  assign gch          = state == GRANT1;
  assign can_load     = !bus.y_valid || bus.y_ready;
  assign bus.i0_ready = state == GRANT0 && can_load;
  assign bus.i1_ready = state == GRANT1 && can_load;
  assign xfer         = (bus.i0_valid && bus.i0_ready) || (bus.i1_valid && bus.i1_ready);
  assign xdata        = gch ? bus.i1_data : bus.i0_data;
  assign xlast        = gch ? bus.i1_last : bus.i0_last;
  assign own_valid    = gch ? bus.i1_valid : bus.i0_valid;
  assign other_valid  = gch ? bus.i0_valid : bus.i1_valid;
  assign rel          = xfer && (xlast || ({1'b0, cnt} + 9'd1 == 9'(MAX_BURST)));
  // A waiting peer always wins the handover; otherwise the current owner may continue.
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = bus.i0_valid && (!bus.i1_valid || !rr) ? GRANT0 : bus.i1_valid ? GRANT1 : IDLE;
    else if (rel)
      nxt = other_valid ? (gch ? GRANT0 : GRANT1) : own_valid ? state : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.sel     <= 1'b0;
      rr          <= 1'b0;
      cnt         <= '0;
      bus.y_valid <= 1'b0;
      bus.y_data  <= '0;
      bus.y_last  <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != IDLE) bus.sel <= nxt == GRANT1;
      if (rel) begin
        cnt <= '0;
        rr  <= !gch;
      end else if (xfer) cnt <= cnt + 8'd1;
      if (xfer) begin
        bus.y_valid <= 1'b1;
        bus.y_data  <= xdata;
        bus.y_last  <= xlast;
      end else if (bus.y_ready) bus.y_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// tb_mux2_stream_arbiter: directed scenarios with hand-computed beat sequences and select timing.
module tb_mux2_stream_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [8:0] q0[$], q1[$], got[$], e[$];
  logic       sel_log[$], yv_log[$];
  logic       en0 = 1'b1, en1 = 1'b1;
  logic       acc0, acc1;

  mux2_stream_arbiter_if #(.DW(8)) bus();
  mux2_stream_arbiter #(.DW(8), .MAX_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.i0_valid = en0 && q0.size() != 0;
    bus.i0_data  = q0.size() != 0 ? q0[0][7:0] : 8'h00;
    bus.i0_last  = q0.size() != 0 ? q0[0][8] : 1'b0;
    bus.i1_valid = en1 && q1.size() != 0;
    bus.i1_data  = q1.size() != 0 ? q1[0][7:0] : 8'h00;
    bus.i1_last  = q1.size() != 0 ? q1[0][8] : 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    acc0 = bus.i0_valid && bus.i0_ready;
    acc1 = bus.i1_valid && bus.i1_ready;
    if (bus.y_valid && bus.y_ready) got.push_back({bus.y_last, bus.y_data});
    @(posedge clk);
    #1;
    sel_log.push_back(bus.sel);
    yv_log.push_back(bus.y_valid);
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    drive();
  endtask

  task automatic run(input int max);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.y_valid) && k < max) begin
      cycle();
      k++;
    end
    check("timeout", 32'(k < max), 32'd1);
  endtask

  task automatic expect_seq(input string tag);
    check({tag, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      check($sformatf("%s_%0d", tag, i), i < got.size() ? 32'(got[i]) : 32'hxxx, 32'(e[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); got.delete();
    en0 = 1'b1; en1 = 1'b1;
    bus.y_ready = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sel_log.delete(); yv_log.delete();
  endtask

  initial begin
    bus.y_ready = 1'b0;
    drive();
    // Reset held while inputs toggle: outputs must stay at their reset values.
    for (int k = 0; k < 4; k++) begin
      bus.i0_valid = k[0]; bus.i1_valid = k[1];
      bus.i0_data = 8'(k * 8'h35); bus.i1_data = 8'(~k);
      bus.i0_last = k[1]; bus.i1_last = k[0]; bus.y_ready = k[0];
      @(posedge clk);
      #1;
      check("rst_sel", bus.sel, 0);
      check("rst_yv", bus.y_valid, 0);
      check("rst_yd", bus.y_data, 0);
      check("rst_yl", bus.y_last, 0);
      check("rst_r0", bus.i0_ready, 0);
      check("rst_r1", bus.i1_ready, 0);
    end
    q1 = '{9'h011, 9'h122};
    bus.y_ready = 1'b1;
    drive();
    rst = 1'b0;
    cycle();
    check("rst_sel1", bus.sel, 1);
    check("rst_r1g", bus.i1_ready, 1);
    run(20);
    e = '{9'h011, 9'h122};
    expect_seq("rst_seq");

    // Round-robin on single-beat packets.
    do_reset();
    q0 = '{9'h101, 9'h102, 9'h103};
    q1 = '{9'h181, 9'h182, 9'h183};
    drive();
    run(30);
    e = '{9'h101, 9'h181, 9'h102, 9'h182, 9'h103, 9'h183};
    expect_seq("rr");
    for (int i = 0; i < 6; i++) check($sformatf("rr_sel_%0d", i), i < sel_log.size() ? 32'(sel_log[i]) : 32'hx, 32'(i % 2));
    for (int i = 1; i < 7; i++) check($sformatf("rr_yv_%0d", i), i < yv_log.size() ? 32'(yv_log[i]) : 32'hx, 1);

    // Burst limit of 4 forces a handover mid-packet.
    do_reset();
    q0 = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
    q1 = '{9'h1A0};
    drive();
    run(40);
    e = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h1A0, 9'h005, 9'h106};
    expect_seq("burst");

    // Backpressure for 3 cycles mid-packet.
    do_reset();
    q0 = '{9'h010, 9'h011, 9'h012, 9'h113};
    drive();
    cycle(); cycle(); cycle();
    bus.y_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_r0", bus.i0_ready, 0);
      check("bp_r1", bus.i1_ready, 0);
      check("bp_yv", bus.y_valid, 1);
      check("bp_yd", bus.y_data, 8'h11);
      cycle();
    end
    bus.y_ready = 1'b1;
    run(30);
    e = '{9'h010, 9'h011, 9'h012, 9'h113};
    expect_seq("bp");

    // Grant held across a valid gap while the peer keeps requesting.
    do_reset();
    q0 = '{9'h021, 9'h122};
    q1 = '{9'h1B0};
    drive();
    cycle(); cycle();
    en0 = 1'b0;
    drive();
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("gap_sel", bus.sel, 0);
      check("gap_r1", bus.i1_ready, 0);
    end
    en0 = 1'b1;
    drive();
    cycle();
    check("gap_sel1", bus.sel, 1);
    run(30);
    e = '{9'h021, 9'h122, 9'h1B0};
    expect_seq("gap");

    // Reset mid-packet clears the buffer without a clock edge and restores rr = 0.
    do_reset();
    bus.y_ready = 1'b0;
    q0 = '{9'h131};
    q1 = '{9'h1C1};
    drive();
    cycle(); cycle();
    check("mr_sel1", bus.sel, 1);
    check("mr_yv1", bus.y_valid, 1);
    check("mr_yd", bus.y_data, 8'h31);
    #2;
    rst = 1'b1;
    #1;
    check("mr_async_yv", bus.y_valid, 0);
    check("mr_async_sel", bus.sel, 0);
    q0.delete(); q1.delete(); got.delete();
    q0 = '{9'h141};
    q1 = '{9'h1D1};
    bus.y_ready = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    check("mr_sel0", bus.sel, 0);
    check("mr_r0", bus.i0_ready, 1);
    check("mr_r1", bus.i1_ready, 0);
    run(30);
    e = '{9'h141, 9'h1D1};
    expect_seq("mr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mux2_stream_arbiter.md
# mux2_stream_arbiter

Two-input stream arbiter that sits directly upstream of the 2:1 select mux. It decides which of two valid/ready sources owns the path, drives the mux select from that decision, and registers the granted beat into a one-entry output buffer. Grants are round-robin and packet-aware: a grant is held until a `last` beat is accepted or a burst limit is reached.

## Interface
- `DW`, default 8: data width of each input and of the output.
- `MAX_BURST`, default 4: maximum beats accepted per grant. Legal range is 1..255.

Ports:
- `clk`, in, 1: single clock. All state is updated on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `i0_valid`, in, 1: channel 0 has a beat.
- `i0_data`, in, DW: channel 0 data.
- `i0_last`, in, 1: channel 0 beat is the last of its packet.
- `i0_ready`, out, 1: channel 0 beat accepted this cycle.
- `i1_valid`, `i1_data`, `i1_last`, `i1_ready`: same as channel 0, for channel 1.
- `sel`, out, 1: current grant owner (0 = i0, 1 = i1). Registered; feeds the downstream mux select.
- `y_valid`, out, 1: output buffer holds a beat.
- `y_data`, out, DW: buffered data.
- `y_last`, out, 1: buffered last flag.
- `y_ready`, in, 1: consumer accepts the beat.

## Operation
- States are IDLE, GRANT0 and GRANT1. A registered `rr` bit holds the preferred channel and resets to 0. A beat counter `cnt` (8 bits) resets to 0.
- IDLE:
  - Only i0_valid high: go to GRANT0.
  - Only i1_valid high: go to GRANT1.
  - Both high: grant channel `rr`.
  - Neither high: stay in IDLE.
- GRANTn:
  - `in_ready = (state == GRANTn) && (!y_valid || y_ready)`.
  - Only the granted channel may see ready high. The other channel's ready is 0.
  - A transfer occurs when `in_valid && in_ready`. On a transfer, the buffer loads data and last, y_valid becomes 1, and `cnt` increments.
- Release: the grant is released on the cycle a transfer carries `last = 1`, or when `cnt + 1 == MAX_BURST`. On release:
  - `cnt` is set to 0.
  - `rr` is set to the other channel.
  - The next state is chosen in the same cycle:
    - other channel valid: GRANT(other);
    - otherwise granted channel still valid: GRANTn again;
    - otherwise IDLE.
- Dropping valid while granted without sending a last beat does not release the grant. The grant stays held, with no timeout.
- `sel`:
  - equals n in GRANTn;
  - holds its previous value in IDLE;
  - updates on the same edge as the state register.
- Output buffer:
  - cleared (y_valid goes to 0) when `y_valid && y_ready` and no new transfer arrives in that cycle;
  - when a simultaneous drain and load occur, it keeps y_valid = 1 with the new data.
- y_data and y_last are stable while `y_valid && !y_ready`.
- Reset values:
  - state IDLE;
  - sel 0, rr 0, cnt 0;
  - y_valid 0, y_data 0, y_last 0;
  - i0_ready 0 and i1_ready 0, because both are derived from state.
- Asserting rst mid-packet abandons the packet immediately: the buffered beat is lost and y_valid is 0 asynchronously. After release, arbitration restarts from IDLE with rr = 0.

## Timing
- Arbitration latency:
  - A request seen in IDLE at cycle t gives grant and sel at t+1.
  - The first transfer can happen at t+1.
  - y_valid is high at t+2.
- Throughput: one beat per cycle while y_ready is held high.
- Switching: on release at cycle t with the other channel waiting, the other channel's ready can be high at t+1. There is no bubble on the output.
- The ready outputs are combinational from state, y_valid and y_ready. There are no combinational paths from input data to outputs.
- Backpressure: with y_valid = 1 and y_ready = 0, both readys are 0.

## Test plan
- Reset:
  - Stimulus: hold rst with all inputs toggling.
  - Required: sel = 0, y_valid = 0, y_data = 0, y_last = 0, both readys 0. After release, with only i1_valid and a 2-beat packet 0x11 then 0x22 (last on the second beat), expect sel = 1 one cycle later and y_data sequence 0x11, 0x22.
- Round-robin:
  - Stimulus: both channels continuously send single-beat packets (last = 1) with y_ready = 1.
  - Required: i0, i1, i0, i1 alternation; sel toggles every cycle after the first grant; no idle output cycles.
- Burst limit:
  - Stimulus: i0 sends 6 beats 0x01..0x06 with last only on 0x06, while i1 sends one beat 0xA0.
  - Required: output order 0x01..0x04, then 0xA0, then 0x05, 0x06 (MAX_BURST = 4).
- Backpressure:
  - Stimulus: y_ready low for 3 cycles mid-packet.
  - Required: y_data holds, i0_ready = 0 throughout, no beat lost or duplicated, and the full sequence matches the input sequence.
- Hold on gap:
  - Stimulus: i0 sends one non-last beat, drops valid for 2 cycles, then sends a last beat; i1 requests the whole time.
  - Required: sel stays 0 until the last beat transfers, then goes to 1.
- Reset mid-packet:
  - Stimulus: assert rst while y_valid = 1.
  - Required: y_valid goes to 0 without waiting for a clock edge; after release the first grant honours rr = 0 when both channels request.
